// File: rtl/shift_reg_univ_n.sv
// Universal shift register with single-step modes and a counted burst shift.
// Define SHIFT_REG_ROTATE_EN to make rot=1 recirculate the shifted-out bit.
module shift_reg_univ_n #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             CLK,
    input  logic             Clear_b,
    input  logic             s1,
    input  logic             s0,
    input  logic [WIDTH-1:0] I_par,
    input  logic             MSB_in,
    input  logic             LSB_in,
    input  logic             start,
    input  logic [CNT_W-1:0] amount,
    input  logic             rot,
    output logic [WIDTH-1:0] A_par,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               left_q, left_d;
    logic               msb_bit, lsb_bit;
    logic [WIDTH-1:0]   shr_val, shl_val;
    logic [1:0]         mode;

    assign mode = {s1, s0};

`ifdef SHIFT_REG_ROTATE_EN
    logic rot_q, rot_d, rot_sel;

    // A burst uses the rot value captured at acceptance, single steps use the live pin.
    always_comb begin
        rot_sel = (state_q == StShift) ? rot_q : rot;
        msb_bit = rot_sel ? a_q[0] : MSB_in;
        lsb_bit = rot_sel ? a_q[WIDTH-1] : LSB_in;
    end

    always_ff @(posedge CLK or negedge Clear_b) begin
        if (!Clear_b) begin
            rot_q <= 1'b0;
        end else begin
            rot_q <= rot_d;
        end
    end
`else
    logic unused_rot;
    assign unused_rot = rot;

    always_comb begin
        msb_bit = MSB_in;
        lsb_bit = LSB_in;
    end
`endif

    assign shr_val = {msb_bit, a_q[WIDTH-1:1]};
    assign shl_val = {a_q[WIDTH-2:0], lsb_bit};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        cnt_d   = cnt_q;
        left_d  = left_q;
`ifdef SHIFT_REG_ROTATE_EN
        rot_d   = rot_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start && (mode == 2'b01 || mode == 2'b10)) begin
                    left_d  = (mode == 2'b10);
                    cnt_d   = amount;
`ifdef SHIFT_REG_ROTATE_EN
                    rot_d   = rot;
`endif
                    state_d = (amount != '0) ? StShift : StDone;
                end else begin
                    unique case (mode)
                        2'b00:   a_d = a_q;
                        2'b01:   a_d = shr_val;
                        2'b10:   a_d = shl_val;
                        default: a_d = I_par;
                    endcase
                end
            end
            StShift: begin
                a_d   = left_q ? shl_val : shr_val;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StDone;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge Clear_b) begin
        if (!Clear_b) begin
            state_q <= StIdle;
            a_q     <= '0;
            cnt_q   <= '0;
            left_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
        end
    end

    assign A_par = a_q;
    assign busy  = (state_q == StShift);
    assign done  = (state_q == StDone);

endmodule

// File: tb/tb_shift_reg_univ_n.sv
// Directed self-checking bench for shift_reg_univ_n (WIDTH=8, CNT_W=4).
module tb_shift_reg_univ_n;

    logic       CLK = 1'b0;
    logic       Clear_b;
    logic       s1, s0;
    logic [7:0] I_par;
    logic       MSB_in, LSB_in;
    logic       start;
    logic [3:0] amount;
    logic       rot;
    logic [7:0] A_par;
    logic       busy, done;

    int checks = 0;
    int errors = 0;

`ifdef SHIFT_REG_ROTATE_EN
    localparam logic [7:0] RotExp = 8'hC0;
`else
    localparam logic [7:0] RotExp = 8'h40;
`endif

    shift_reg_univ_n #(.WIDTH(8), .CNT_W(4)) dut (
        .CLK    (CLK),
        .Clear_b(Clear_b),
        .s1     (s1),
        .s0     (s0),
        .I_par  (I_par),
        .MSB_in (MSB_in),
        .LSB_in (LSB_in),
        .start  (start),
        .amount (amount),
        .rot    (rot),
        .A_par  (A_par),
        .busy   (busy),
        .done   (done)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic load(input logic [7:0] v);
        {s1, s0} = 2'b11;
        I_par = v;
        start = 1'b0;
        tick();
        {s1, s0} = 2'b00;
    endtask

    task automatic test_reset();
        Clear_b = 1'b0;
        {s1, s0} = 2'b00;
        I_par = 8'h00; MSB_in = 1'b0; LSB_in = 1'b0;
        start = 1'b0; amount = 4'd0; rot = 1'b0;
        #1;
        checks++; if (A_par !== 8'h00) begin errors++; $display("FAIL reset_a: got %h want 00", A_par); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        #11;
        Clear_b = 1'b1;
        tick();
    endtask

    task automatic test_single_step();
        load(8'hA5);
        checks++; if (A_par !== 8'hA5) begin errors++; $display("FAIL load: got %h want a5", A_par); end
        tick();
        checks++; if (A_par !== 8'hA5) begin errors++; $display("FAIL hold: got %h want a5", A_par); end
        {s1, s0} = 2'b01; MSB_in = 1'b1;
        tick();
        checks++; if (A_par !== 8'hD2) begin errors++; $display("FAIL shift_right: got %h want d2", A_par); end
        {s1, s0} = 2'b10; LSB_in = 1'b1;
        tick();
        checks++; if (A_par !== 8'hA5) begin errors++; $display("FAIL shift_left: got %h want a5", A_par); end
        // start with load mode is ignored: plain load happens
        {s1, s0} = 2'b11; I_par = 8'h3C; start = 1'b1; amount = 4'd2;
        tick();
        start = 1'b0; {s1, s0} = 2'b00;
        checks++; if (A_par !== 8'h3C || busy !== 1'b0) begin
            errors++; $display("FAIL start_load_ignored: got a=%h busy=%b want 3c 0", A_par, busy);
        end
    endtask

    task automatic test_burst_left();
        logic [7:0] exp_a [4];
        exp_a[0] = 8'h81; exp_a[1] = 8'h02; exp_a[2] = 8'h04; exp_a[3] = 8'h08;
        load(8'h81);
        {s1, s0} = 2'b10; LSB_in = 1'b0; start = 1'b1; amount = 4'd3;
        tick();
        // inputs below must be ignored during the burst
        start = 1'b0; {s1, s0} = 2'b11; I_par = 8'hFF; amount = 4'd9;
        for (int i = 0; i < 3; i++) begin
            checks++; if (busy !== 1'b1 || done !== 1'b0 || A_par !== exp_a[i]) begin
                errors++;
                $display("FAIL burst_cycle%0d: got busy=%b done=%b a=%h want 1 0 %h",
                         i, busy, done, A_par, exp_a[i]);
            end
            tick();
        end
        checks++; if (busy !== 1'b0 || done !== 1'b1 || A_par !== exp_a[3]) begin
            errors++; $display("FAIL burst_done: got busy=%b done=%b a=%h want 0 1 08", busy, done, A_par);
        end
        {s1, s0} = 2'b00;
        tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0 || A_par !== 8'h08) begin
            errors++; $display("FAIL burst_after: got busy=%b done=%b a=%h want 0 0 08", busy, done, A_par);
        end
    endtask

    task automatic test_rotate();
        load(8'h81);
        {s1, s0} = 2'b01; rot = 1'b1; MSB_in = 1'b0; start = 1'b1; amount = 4'd1;
        tick();
        start = 1'b0; rot = 1'b0; {s1, s0} = 2'b00;
        checks++; if (busy !== 1'b1 || A_par !== 8'h81) begin
            errors++; $display("FAIL rotate_accept: got busy=%b a=%h want 1 81", busy, A_par);
        end
        tick();
        checks++; if (done !== 1'b1 || A_par !== RotExp) begin
            errors++; $display("FAIL rotate: got done=%b a=%h want 1 %h", done, A_par, RotExp);
        end
        tick();
    endtask

    task automatic test_reset_mid_burst();
        int seen_done = 0;
        load(8'h81);
        {s1, s0} = 2'b10; LSB_in = 1'b1; start = 1'b1; amount = 4'd5;
        tick();
        start = 1'b0; {s1, s0} = 2'b00;
        tick();
        checks++; if (busy !== 1'b1 || A_par !== 8'h03) begin
            errors++; $display("FAIL mid_pre: got busy=%b a=%h want 1 03", busy, A_par);
        end
        #2 Clear_b = 1'b0;
        #1;
        checks++; if (A_par !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL mid_reset: got a=%h busy=%b done=%b want 00 0 0", A_par, busy, done);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) seen_done++;
        end
        #3 Clear_b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) seen_done++;
        end
        checks++; if (seen_done !== 0 || A_par !== 8'h00) begin
            errors++; $display("FAIL mid_no_done: got stray=%0d a=%h want 0 00", seen_done, A_par);
        end
        load(8'h5A);
        checks++; if (A_par !== 8'h5A) begin errors++; $display("FAIL mid_resume: got %h want 5a", A_par); end
    endtask

    task automatic test_zero_burst();
        load(8'h5A);
        {s1, s0} = 2'b10; LSB_in = 1'b1; start = 1'b1; amount = 4'd0;
        tick();
        start = 1'b0; {s1, s0} = 2'b00;
        checks++; if (busy !== 1'b0 || done !== 1'b1 || A_par !== 8'h5A) begin
            errors++; $display("FAIL zero_burst: got busy=%b done=%b a=%h want 0 1 5a", busy, done, A_par);
        end
        tick();
        checks++; if (busy !== 1'b0 || done !== 1'b0 || A_par !== 8'h5A) begin
            errors++; $display("FAIL zero_after: got busy=%b done=%b a=%h want 0 0 5a", busy, done, A_par);
        end
    endtask

    task automatic test_max_burst();
        int busy_cycles = 0;
        int guard = 0;
        load(8'h00);
        {s1, s0} = 2'b10; LSB_in = 1'b1; rot = 1'b0; start = 1'b1; amount = 4'd15;
        tick();
        start = 1'b0; {s1, s0} = 2'b00;
        while (done !== 1'b1 && guard < 30) begin
            if (busy === 1'b1) busy_cycles++;
            guard++;
            tick();
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL max_timeout: got done=%b want 1", done); end
        checks++; if (busy_cycles !== 15 || A_par !== 8'hFF) begin
            errors++; $display("FAIL max_burst: got busy_cycles=%0d a=%h want 15 ff", busy_cycles, A_par);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_burst_left();
        test_rotate();
        test_reset_mid_burst();
        test_zero_burst();
        test_max_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_reg_univ_n.md
SHIFT_REG_UNIV_N -- requirements
Module: shift_reg_univ_n

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, register width (min 2).
REQ-002 The block SHALL have parameter CNT_W, default 4, width of the burst shift amount.
REQ-003 The block SHALL have port CLK, input, 1, sole clock; all state updates on its rising edge.
REQ-004 The block SHALL have port Clear_b, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have ports s1, s0, input, 1 each, mode select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-006 The block SHALL have port I_par, input, WIDTH, parallel load data.
REQ-007 The block SHALL have port MSB_in, input, 1, serial bit entering A_par[WIDTH-1] on a right shift.
REQ-008 The block SHALL have port LSB_in, input, 1, serial bit entering A_par[0] on a left shift.
REQ-009 The block SHALL have port start, input, 1, burst shift request.
REQ-010 The block SHALL have port amount, input, CNT_W, number of positions for a burst.
REQ-011 The block SHALL have port rot, input, 1, rotate select; used only when SHIFT_REG_ROTATE_EN is defined.
REQ-012 The block SHALL have port A_par, output, WIDTH, register contents.
REQ-013 The block SHALL have port busy, output, 1, high while a burst is shifting.
REQ-014 The block SHALL have port done, output, 1, one-cycle burst completion pulse.

Function
REQ-015 The block SHALL implement a registered FSM with states IDLE, SHIFT and DONE; busy = (state==SHIFT) and done = (state==DONE).
REQ-016 In IDLE with start=0, each edge SHALL apply the {s1,s0} mode to A_par in a single step: hold, right shift ({MSB_in, A_par[WIDTH-1:1]}), left shift ({A_par[WIDTH-2:0], LSB_in}) or load I_par.
REQ-017 In IDLE with start=1 and {s1,s0} = 01 or 10, the edge SHALL latch the direction and amount, leave A_par unchanged, and go to SHIFT if amount>0 or DONE if amount=0.
REQ-018 In IDLE with start=1 and {s1,s0} = 00 or 11, start SHALL be ignored and REQ-016 SHALL apply.
REQ-019 In SHIFT, each edge SHALL perform one shift in the latched direction, sampling MSB_in/LSB_in on that edge, and decrement the remaining count; the edge performing the final shift SHALL move to DONE.
REQ-020 busy SHALL be high for exactly amount cycles; the final value SHALL appear on A_par in the same cycle done is high.
REQ-021 In SHIFT and DONE, s1, s0, I_par, start and amount SHALL be ignored.
REQ-022 DONE SHALL hold A_par and return to IDLE on the next edge.
REQ-023 Amount arithmetic SHALL be unsigned CNT_W bits, so the maximum burst is 2^CNT_W-1; an amount >= WIDTH without rotate SHALL fill the register entirely with serial-input bits.

Reset
REQ-024 Clear_b=0 SHALL immediately set A_par=0, state=IDLE, busy=0, done=0 and count=0, independent of CLK.
REQ-025 Reset asserted during SHIFT or DONE SHALL abort the burst with no done pulse.
REQ-026 After Clear_b deasserts, operation SHALL resume from IDLE on the next rising edge.

Configuration
REQ-027 With macro SHIFT_REG_ROTATE_EN defined and rot=1, every shift (single-step or burst) SHALL insert the bit shifted out of the opposite end instead of MSB_in/LSB_in; rot SHALL be latched at burst acceptance.
REQ-028 Without SHIFT_REG_ROTATE_EN, the rot port SHALL exist and SHALL be ignored; shifts SHALL always use the serial inputs.

Verification
REQ-029 The bench SHALL cover load: s=11, I_par=8'hA5 -> A_par=8'hA5 after 1 edge.
REQ-030 The bench SHALL cover single right shift: A_par=8'hA5, s=01, MSB_in=1 -> 8'hD2 after 1 edge.
REQ-031 The bench SHALL cover a left burst: A_par=8'h81, s=10, LSB_in=0, start=1, amount=3 -> busy high 3 cycles, then done high 1 cycle with A_par=8'h08.
REQ-032 The bench SHALL cover rotate: A_par=8'h81, s=01, rot=1, MSB_in=0, start, amount=1 -> A_par=8'hC0 with the macro defined, 8'h40 without it.
REQ-033 The bench SHALL cover reset mid-burst: Clear_b=0 during the second SHIFT cycle -> A_par=0 and busy=0 immediately, with no done pulse.
REQ-034 The bench SHALL cover a zero burst: start=1, s=10, amount=0 -> busy never high, done high 1 cycle after acceptance, A_par unchanged.
